// File: rtl/sifive_insight_hpm_counter_bank.sv
// sifive_insight_hpm_counter_bank
// Bank of NUM_COUNTERS hardware performance-monitor counters. Raw hart events
// are registered once (ev_q) and then masked per counter. Each counter either
// ORs its masked events (step 0/1) or adds their popcount. Software can
// rewrite the event select and preload the count.
// Optional feature macro: SIFIVE_INSIGHT_HPM_OVF_IRQ_EN enables the sticky
// overflow flags, ovf_clr and irq. Without the macro, counters wrap silently
// and ovf/irq are tied low.
module sifive_insight_hpm_counter_bank #(
    parameter int  NUM_COUNTERS  = 4,
    parameter int  COUNTER_WIDTH = 40,
    parameter int  NUM_EVENTS    = 24,
    localparam int IW            = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [NUM_EVENTS-1:0]                  events,
    input  logic [NUM_COUNTERS-1:0]                inhibit,
    input  logic                                   sel_we,
    input  logic [IW-1:0]                          sel_idx,
    input  logic [31:0]                            sel_wdata,
    input  logic                                   cnt_we,
    input  logic [IW-1:0]                          cnt_idx,
    input  logic [COUNTER_WIDTH-1:0]               cnt_wdata,
    input  logic [NUM_COUNTERS-1:0]                ovf_clr,
    output logic [32*NUM_COUNTERS-1:0]             event_sel,
    output logic [COUNTER_WIDTH*NUM_COUNTERS-1:0]  count,
    output logic [NUM_COUNTERS-1:0]                inc,
    output logic [NUM_COUNTERS-1:0]                ovf,
    output logic                                   irq
);

    localparam int SW = $clog2(NUM_EVENTS + 1);
    // Writable select bits: the event mask and the accumulate-mode bit.
    localparam logic [31:0] SEL_MASK =
        32'h8000_0000 | 32'((64'd1 << NUM_EVENTS) - 64'd1);

    logic [NUM_EVENTS-1:0]    r_ev_q;
    logic [31:0]              r_sel [NUM_COUNTERS];
    logic [COUNTER_WIDTH-1:0] r_cnt [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  r_inc;

    logic [NUM_EVENTS-1:0]    w_mask [NUM_COUNTERS];
    logic [SW-1:0]            w_step [NUM_COUNTERS];
    logic [COUNTER_WIDTH:0]   w_sum  [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0]  w_pre;
    logic [NUM_COUNTERS-1:0]  w_selw;
    logic [NUM_COUNTERS-1:0]  w_adv;
    logic [NUM_COUNTERS-1:0]  w_wrap;

    // Per-counter step, write decode and carry-extended next count.
    // Index compares against the loop bound also reject out-of-range indices.
    always_comb begin
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            w_mask[i] = r_ev_q & r_sel[i][NUM_EVENTS-1:0];
            w_step[i] = '0;
            if (r_sel[i][31]) begin
                for (int unsigned j = 0; j < NUM_EVENTS; j++) begin
                    w_step[i] = w_step[i] + SW'(w_mask[i][j]);
                end
            end else begin
                w_step[i] = SW'(|w_mask[i]);
            end
            w_pre[i]  = cnt_we && (32'(cnt_idx) == i);
            w_selw[i] = sel_we && (32'(sel_idx) == i);
            w_adv[i]  = !inhibit[i] && (w_step[i] != '0) && !w_pre[i];
            w_sum[i]  = {1'b0, r_cnt[i]} + (COUNTER_WIDTH + 1)'(w_step[i]);
            w_wrap[i] = w_adv[i] && w_sum[i][COUNTER_WIDTH];
        end
    end

    // Event pipeline, select registers, counts and advance flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ev_q <= '0;
            r_inc  <= '0;
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                r_sel[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_ev_q <= events;
            r_inc  <= w_adv;
            for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
                if (w_selw[i]) begin
                    r_sel[i] <= sel_wdata & SEL_MASK;
                end
                if (w_pre[i]) begin
                    r_cnt[i] <= cnt_wdata;
                end else if (w_adv[i]) begin
                    r_cnt[i] <= w_sum[i][COUNTER_WIDTH-1:0];
                end
            end
        end
    end

    // Flatten register arrays onto the packed output buses.
    always_comb begin
        event_sel = '0;
        count     = '0;
        for (int unsigned i = 0; i < NUM_COUNTERS; i++) begin
            event_sel[32*i +: 32]                       = r_sel[i];
            count[COUNTER_WIDTH*i +: COUNTER_WIDTH]     = r_cnt[i];
        end
    end

    assign inc = r_inc;

`ifdef SIFIVE_INSIGHT_HPM_OVF_IRQ_EN
    logic [NUM_COUNTERS-1:0] r_ovf;

    // Sticky overflow: a wrap in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~ovf_clr) | w_wrap;
        end
    end

    assign ovf = r_ovf;
    assign irq = |r_ovf;

    logic w_unused;
    assign w_unused = ^sel_wdata;
`else
    assign ovf = '0;
    assign irq = 1'b0;

    logic w_unused;
    assign w_unused = ^{sel_wdata, ovf_clr, w_wrap};
`endif

endmodule

// File: tb/tb_sifive_insight_hpm_counter_bank.sv
// Self-checking bench for sifive_insight_hpm_counter_bank: directed scenarios
// followed by randomized traffic, all compared every cycle against a
// behavioural reference model of the counter bank.
module tb_sifive_insight_hpm_counter_bank;

    localparam int NC = 4;
    localparam int CW = 40;
    localparam int NE = 24;
    localparam int IW = 2;
    localparam logic [63:0] MAXV = (64'd1 << CW) - 64'd1;
`ifdef SIFIVE_INSIGHT_HPM_OVF_IRQ_EN
    localparam logic OVF_EN = 1'b1;
`else
    localparam logic OVF_EN = 1'b0;
`endif

    logic                clock = 1'b0;
    logic                reset;
    logic [NE-1:0]       events;
    logic [NC-1:0]       inhibit;
    logic                sel_we;
    logic [IW-1:0]       sel_idx;
    logic [31:0]         sel_wdata;
    logic                cnt_we;
    logic [IW-1:0]       cnt_idx;
    logic [CW-1:0]       cnt_wdata;
    logic [NC-1:0]       ovf_clr;
    logic [32*NC-1:0]    event_sel;
    logic [CW*NC-1:0]    count;
    logic [NC-1:0]       inc;
    logic [NC-1:0]       ovf;
    logic                irq;

    sifive_insight_hpm_counter_bank #(
        .NUM_COUNTERS (NC),
        .COUNTER_WIDTH(CW),
        .NUM_EVENTS   (NE)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .events   (events),
        .inhibit  (inhibit),
        .sel_we   (sel_we),
        .sel_idx  (sel_idx),
        .sel_wdata(sel_wdata),
        .cnt_we   (cnt_we),
        .cnt_idx  (cnt_idx),
        .cnt_wdata(cnt_wdata),
        .ovf_clr  (ovf_clr),
        .event_sel(event_sel),
        .count    (count),
        .inc      (inc),
        .ovf      (ovf),
        .irq      (irq)
    );

    always #5 clock = ~clock;

    // Reference model state.
    logic [NE-1:0] m_evq;
    logic [31:0]   m_sel [NC];
    logic [63:0]   m_cnt [NC];
    logic [NC-1:0] m_inc;
    logic [NC-1:0] m_ovf;

    int  n_vec  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Apply one clock edge to the model using the inputs the DUT sees.
    task automatic model_step();
        logic [NE-1:0] mk;
        int            pc;
        logic [63:0]   st;
        logic          set;
        if (reset) begin
            m_evq = '0;
            m_inc = '0;
            m_ovf = '0;
            for (int i = 0; i < NC; i++) begin
                m_sel[i] = '0;
                m_cnt[i] = '0;
            end
            return;
        end
        for (int i = 0; i < NC; i++) begin
            mk  = m_evq & m_sel[i][NE-1:0];
            pc  = $countones(mk);
            st  = m_sel[i][31] ? 64'(pc) : ((pc != 0) ? 64'd1 : 64'd0);
            set = 1'b0;
            m_inc[i] = 1'b0;
            if (cnt_we && int'(cnt_idx) == i) begin
                m_cnt[i] = 64'(cnt_wdata);
            end else if (!inhibit[i] && st != 0) begin
                m_inc[i] = 1'b1;
                if (m_cnt[i] + st > MAXV) begin
                    m_cnt[i] = m_cnt[i] + st - (MAXV + 64'd1);
                    set = 1'b1;
                end else begin
                    m_cnt[i] = m_cnt[i] + st;
                end
            end
            m_ovf[i] = OVF_EN & ((m_ovf[i] & ~ovf_clr[i]) | set);
        end
        if (sel_we && int'(sel_idx) < NC) begin
            m_sel[sel_idx] = {sel_wdata[31], 7'd0, sel_wdata[NE-1:0]};
        end
        m_evq = events;
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
    endtask

    // Compare every output against the model each cycle, away from the edge.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < NC; i++) begin
                check($sformatf("event_sel[%0d]", i), 64'(event_sel[32*i +: 32]), 64'(m_sel[i]));
                check($sformatf("count[%0d]", i), 64'(count[CW*i +: CW]), m_cnt[i]);
                check($sformatf("inc[%0d]", i), 64'(inc[i]), 64'(m_inc[i]));
                check($sformatf("ovf[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
            end
            check("irq", 64'(irq), 64'(|m_ovf));
        end
    end

    function automatic logic [63:0] cnt_of(input int i);
        return 64'(count[CW*i +: CW]);
    endfunction

    task automatic idle_inputs();
        events = '0; inhibit = '0; sel_we = 0; sel_idx = '0; sel_wdata = '0;
        cnt_we = 0; cnt_idx = '0; cnt_wdata = '0; ovf_clr = '0;
    endtask

    task automatic flush();
        events = '0;
        cyc();
        cyc();
    endtask

    task automatic wr_sel(input int idx, input logic [31:0] d);
        sel_we = 1; sel_idx = IW'(idx); sel_wdata = d;
        cyc();
        sel_we = 0;
    endtask

    initial begin
        logic [31:0] r32;
        reset = 1'b1;
        idle_inputs();
        for (int i = 0; i < NC; i++) begin m_sel[i] = '0; m_cnt[i] = '0; end
        m_evq = '0; m_inc = '0; m_ovf = '0;
        cyc();
        cyc();
        reset = 1'b0;
        chk_en = 1'b1;

        // Idle with all events high and zero selects: nothing counts.
        events = '1;
        for (int k = 0; k < 10; k++) cyc();
        check("lit_idle_count", 64'(|count), 64'd0);
        check("lit_idle_inc", 64'(inc), 64'd0);

        // OR mode on counter 0.
        events = '0;
        wr_sel(0, 32'h0000_0005);
        events = 24'h5;
        cyc();
        check("lit_or_inc_latency1", 64'(inc[0]), 64'd0);
        cyc();
        check("lit_or_inc_latency2", 64'(inc[0]), 64'd1);
        cyc();
        events = '0;
        cyc();
        cyc();
        check("lit_or_count0", cnt_of(0), 64'd3);
        check("lit_or_model0", m_cnt[0], 64'd3);

        // Popcount mode on counter 1, then an inhibited pulse.
        wr_sel(1, 32'h8000_000F);
        events = 24'hF;
        cyc();
        cyc();
        events = '0;
        cyc();
        cyc();
        check("lit_pop_count1", cnt_of(1), 64'd8);
        check("lit_pop_model1", m_cnt[1], 64'd8);
        events = 24'hF;
        cyc();
        events = '0;
        inhibit = 4'b0010;
        cyc();
        inhibit = '0;
        cyc();
        check("lit_inhibit_count1", cnt_of(1), 64'd8);

        // Wrap and overflow on counter 2.
        cnt_we = 1; cnt_idx = 2'd2; cnt_wdata = CW'(MAXV - 64'd1);
        sel_we = 1; sel_idx = 2'd2; sel_wdata = 32'h8000_0007;
        cyc();
        cnt_we = 0; sel_we = 0;
        events = 24'h7;
        cyc();
        events = '0;
        cyc();
        check("lit_wrap_count2", cnt_of(2), 64'd1);
        check("lit_wrap_model2", m_cnt[2], 64'd1);
        check("lit_wrap_ovf2", 64'(ovf[2]), 64'(OVF_EN));
        check("lit_wrap_irq", 64'(irq), 64'(OVF_EN));
        ovf_clr = 4'b0100;
        cyc();
        ovf_clr = '0;
        check("lit_clr_ovf2", 64'(ovf[2]), 64'd0);
        flush();

        // Preload colliding with a counting step on counter 0.
        events = 24'h1;
        cyc();
        cnt_we = 1; cnt_idx = 2'd0; cnt_wdata = CW'(100);
        cyc();
        check("lit_coll_count0", cnt_of(0), 64'd100);
        check("lit_coll_inc0", 64'(inc[0]), 64'd0);
        cnt_we = 0;
        events = '0;
        cyc();
        cyc();

        // Overflow coincident with ovf_clr: set wins.
        cnt_we = 1; cnt_idx = 2'd2; cnt_wdata = CW'(MAXV);
        events = 24'h1;
        cyc();
        cnt_we = 0;
        events = '0;
        ovf_clr = 4'b0100;
        cyc();
        ovf_clr = '0;
        check("lit_setwins_ovf2", 64'(ovf[2]), 64'(OVF_EN));
        check("lit_setwins_count2", cnt_of(2), 64'd0);
        flush();

        // Mid-run reset while events stream.
        for (int i = 0; i < NC; i++) wr_sel(i, 32'h80FF_FFFF);
        events = '1;
        for (int k = 0; k < 5; k++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        check("lit_rst_count", 64'(|count), 64'd0);
        check("lit_rst_inc", 64'(inc), 64'd0);
        cyc();
        check("lit_rst_inc2", 64'(inc), 64'd0);
        check("lit_rst_ovf", 64'(ovf), 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            r32 = $urandom;
            events = r32[NE-1:0];
            r32 = $urandom;
            inhibit = ($urandom_range(0, 5) == 0) ? r32[NC-1:0] : '0;
            sel_we = ($urandom_range(0, 9) == 0);
            r32 = $urandom;
            sel_idx = r32[IW-1:0];
            sel_wdata = $urandom;
            cnt_we = ($urandom_range(0, 15) == 0);
            r32 = $urandom;
            cnt_idx = r32[IW-1:0];
            if ($urandom_range(0, 1) == 0)
                cnt_wdata = CW'(MAXV - 64'($urandom_range(0, 40)));
            else
                cnt_wdata = CW'({$urandom, $urandom});
            r32 = $urandom;
            ovf_clr = ($urandom_range(0, 7) == 0) ? r32[NC-1:0] : '0;
            reset = ($urandom_range(0, 599) == 0);
            cyc();
        end
        reset = 1'b0;
        idle_inputs();
        cyc();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/sifive_insight_hpm_counter_bank.md
# sifive_insight_hpm_counter_bank

Parametrised bank of hardware performance-monitor counters for the Insight trace/debug fabric. It generalises the single event-select/increment counter channel to NUM_COUNTERS independent counters. Each counter has a programmable event mask, an OR or popcount accumulate mode, per-counter inhibit, and software preload. It sits between the hart's raw event bus and the debug/CSR read path, with an optional overflow interrupt.

## Interface
Parameters:
- NUM_COUNTERS, 4, number of counter channels (1..16)
- COUNTER_WIDTH, 40, bits per counter (8..64)
- NUM_EVENTS, 24, raw event lines (1..31); must fit below bit 31 of event_sel

Ports:
- clock  in  1  sole clock; all state on rising edge
- reset  in  1  synchronous, active-high
- events  in  NUM_EVENTS  raw per-cycle hart event pulses
- inhibit  in  NUM_COUNTERS  per-counter count-inhibit (1 = hold)
- sel_we  in  1  write event_sel of counter sel_idx
- sel_idx  in  $clog2(NUM_COUNTERS) (min 1)  target counter for sel write
- sel_wdata  in  32  [NUM_EVENTS-1:0] event mask, [31] accumulate mode, other bits ignored/read 0
- cnt_we  in  1  preload count of counter cnt_idx
- cnt_idx  in  $clog2(NUM_COUNTERS) (min 1)  target counter for preload
- cnt_wdata  in  COUNTER_WIDTH  preload value
- ovf_clr  in  NUM_COUNTERS  per-counter sticky-overflow clear
- event_sel  out  32*NUM_COUNTERS  current select registers, counter i at [32i+31:32i]
- count  out  COUNTER_WIDTH*NUM_COUNTERS  current counts, counter i at slice i
- inc  out  NUM_COUNTERS  registered: counter i advanced this cycle
- ovf  out  NUM_COUNTERS  sticky overflow flags
- irq  out  1  OR of ovf

## Operation
- Stage 0: events registered into ev_q (1 cycle).
- Stage 1: per counter, m = ev_q & event_sel[i][NUM_EVENTS-1:0].
- Step: mode 0 (bit31=0): step = |m ? 1 : 0. Mode 1: step = popcount(m).
- Counting: if !inhibit[i] and step != 0, count[i] <= count[i] + step, modulo 2^COUNTER_WIDTH. inc[i] <= 1 that cycle, else 0.
- Overflow: carry out of COUNTER_WIDTH (sum ≥ 2^COUNTER_WIDTH) wraps the count to the low bits and sets ovf[i].
- event_sel = 0 (reset value) means the counter never counts.
- Preload: cnt_we writes cnt_wdata to count[cnt_idx]. It beats any increment in the same cycle, so that cycle's step is dropped, no ovf is set and inc = 0.
- sel write takes effect for ev_q evaluated in the next cycle. The current cycle uses the old mask.
- ovf_clr[i] and overflow in the same cycle: set wins.
- inhibit is sampled in stage 1, in the same cycle as the masked event.
- Out-of-range sel_idx/cnt_idx (≥ NUM_COUNTERS): write ignored.

## Timing
- Event on events at edge t → count and inc update at edge t+2 (2-cycle latency). Sustained throughput: one update per counter per cycle.
- Writes to event_sel/count are visible on outputs 1 cycle after the write edge.
- ovf visible with the wrapping count update. irq is combinational OR of registered ovf, so it asserts in the same cycle as ovf.
- Reset values: ev_q = 0, event_sel = 0, count = 0, inc = 0, ovf = 0, irq = 0.
- Reset mid-operation: in-flight ev_q events are discarded and no increment lands after reset deasserts.
- No backpressure; no handshake on writes (single-cycle strobes).

## Configuration
- SIFIVE_INSIGHT_HPM_OVF_IRQ_EN defined: the ovf sticky flags, ovf_clr and irq behave as above.
- SIFIVE_INSIGHT_HPM_OVF_IRQ_EN undefined: counters still wrap silently. ovf and irq are tied 0, ovf_clr is ignored, and no overflow flops are instantiated. Ports stay present in both builds.

## Test plan
- Reset then idle: drive events = all-ones for 10 cycles with event_sel = 0 → count = 0, inc = 0, ovf = 0 throughout.
- OR mode: event_sel[0] = 0x0000_0005, pulse events = 0x5 for 3 cycles → count[0] = 3, first inc[0] two cycles after first pulse.
- Popcount mode: event_sel[1] = 0x8000_000F, events = 0xF for 2 cycles → count[1] = 8; inhibit[1] asserted for a third pulse → stays 8.
- Wrap/overflow: preload count[2] = 2^40−2, popcount mode mask 0x7, events = 0x7 once → count[2] = 1, ovf[2] = 1, irq = 1. ovf_clr[2] → ovf[2] = 0 next cycle.
- Collision: cnt_we to counter 0 with cnt_wdata = 100 in the same cycle as a counting step → count[0] = 100, inc[0] = 0. Also ovf_clr coincident with overflow → ovf stays 1.
- Mid-run reset: events streaming, assert reset one cycle → all outputs 0 and no increment for the two cycles after deassert.
